// File: rtl/ir_transmitter.sv
// Pulse-distance IR frame transmitter: header mark/space, MSB-first payload bits,
// stop mark, with a carrier of four generator ticks per cycle gated by the envelope.
module ir_transmitter #(
  parameter int DATA_WIDTH      = 32,
  parameter int TICKS_PER_UNIT  = 64,
  parameter int HDR_MARK_UNITS  = 16,
  parameter int HDR_SPACE_UNITS = 8,
  parameter int ONE_SPACE_UNITS = 3
) (
  input  logic                  In_Clock,
  input  logic                  In_Reset,
  input  logic                  In_Clock_Pulse,
  input  logic                  In_Valid,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic                  Out_Ready,
  output logic                  Out_Busy,
  output logic                  Out_Envelope,
  output logic                  Out_IR,
  output logic                  Out_Done
);

  localparam int MAX_UNITS_A = (HDR_MARK_UNITS > HDR_SPACE_UNITS) ? HDR_MARK_UNITS : HDR_SPACE_UNITS;
  localparam int MAX_UNITS_B = (ONE_SPACE_UNITS > 1) ? ONE_SPACE_UNITS : 1;
  localparam int MAX_UNITS   = (MAX_UNITS_A > MAX_UNITS_B) ? MAX_UNITS_A : MAX_UNITS_B;
  localparam int MAX_TICKS   = MAX_UNITS * TICKS_PER_UNIT;
  localparam int SEG_W       = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int BIT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [SEG_W-1:0] HDR_MARK_LAST  = SEG_W'(HDR_MARK_UNITS * TICKS_PER_UNIT - 1);
  localparam logic [SEG_W-1:0] HDR_SPACE_LAST = SEG_W'(HDR_SPACE_UNITS * TICKS_PER_UNIT - 1);
  localparam logic [SEG_W-1:0] ONE_LAST       = SEG_W'(ONE_SPACE_UNITS * TICKS_PER_UNIT - 1);
  localparam logic [SEG_W-1:0] UNIT_LAST      = SEG_W'(TICKS_PER_UNIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT       = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR_MARK,
    HDR_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } state_t;

  state_t                state_reg, state_next;
  logic                  prev_reg;
  logic [SEG_W-1:0]      seg_cnt_reg, seg_cnt_next;
  logic [1:0]            phase_reg, phase_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                  done_reg, done_next;
  logic                  ready_reg, env_reg;
  logic                  tick, seg_end, mark_cur, mark_next;
  logic [SEG_W-1:0]      seg_last;

  always_comb begin
    tick         = In_Clock_Pulse & ~prev_reg;
    state_next   = state_reg;
    seg_cnt_next = seg_cnt_reg;
    phase_next   = phase_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    done_next    = 1'b0;
    seg_end      = 1'b0;
    seg_last     = UNIT_LAST;
    mark_cur     = state_reg inside {HDR_MARK, BIT_MARK, STOP_MARK};

    case (state_reg)
      HDR_MARK:  seg_last = HDR_MARK_LAST;
      HDR_SPACE: seg_last = HDR_SPACE_LAST;
      BIT_SPACE: seg_last = shift_reg[DATA_WIDTH-1] ? ONE_LAST : UNIT_LAST;
      default:   seg_last = UNIT_LAST;
    endcase

    // Ticks are ignored in IDLE, so a tick coincident with acceptance is never counted.
    if (state_reg != IDLE && tick) begin
      seg_cnt_next = seg_cnt_reg + 1'b1;
      seg_end      = (seg_cnt_reg == seg_last);
      if (mark_cur) phase_next = phase_reg + 2'd1;
    end

    case (state_reg)
      IDLE: begin
        if (In_Valid) begin
          shift_next   = In_Data;
          bit_cnt_next = '0;
          state_next   = HDR_MARK;
        end
      end
      HDR_MARK:  if (seg_end) state_next = HDR_SPACE;
      HDR_SPACE: if (seg_end) state_next = BIT_MARK;
      BIT_MARK:  if (seg_end) state_next = BIT_SPACE;
      BIT_SPACE: begin
        if (seg_end) begin
          shift_next   = shift_reg << 1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          state_next   = (bit_cnt_reg == LAST_BIT) ? STOP_MARK : BIT_MARK;
        end
      end
      STOP_MARK: begin
        if (seg_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Every segment starts from a clean count and the carrier restarts high.
    if (state_next != state_reg) begin
      seg_cnt_next = '0;
      phase_next   = 2'd0;
    end
    mark_next = state_next inside {HDR_MARK, BIT_MARK, STOP_MARK};
  end

  always_ff @(posedge In_Clock) begin
    if (In_Reset) begin
      state_reg   <= IDLE;
      prev_reg    <= 1'b1;
      seg_cnt_reg <= '0;
      phase_reg   <= 2'd0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      done_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      env_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prev_reg    <= In_Clock_Pulse;
      seg_cnt_reg <= seg_cnt_next;
      phase_reg   <= phase_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      done_reg    <= done_next;
      ready_reg   <= (state_next == IDLE);
      env_reg     <= mark_next;
    end
  end

  assign Out_Ready    = ready_reg;
  assign Out_Busy     = ~ready_reg;
  assign Out_Envelope = env_reg;
  assign Out_IR       = env_reg & ~phase_reg[1];
  assign Out_Done     = done_reg;

endmodule

// File: tb/tb_ir_transmitter.sv
// Bench for ir_transmitter: accepted payloads feed a scoreboard queue; a monitor measures
// envelope run lengths in ticks and the carrier, and checks each frame on Out_Done.
module tb_ir_transmitter;
  localparam int DW = 32;
  localparam int T  = 8;   // short unit keeps several full frames inside the cycle budget
  localparam int HM = 16;
  localparam int HS = 8;
  localparam int OS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          ready, busy, env, ir, done;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  int            mark_idx = 0;
  int            ir_err = 0;
  int            frames_done = 0;
  bit            pulse_run = 1'b0;
  logic          pulse_hold = 1'b1;

  logic          m_prev = 1'b1;
  int            m_cnt = 0;
  logic          m_env = 1'b0;
  bit            m_in_frame = 1'b0;
  int            m_runs[$];
  int            g_hold = 0;

  ir_transmitter #(
    .DATA_WIDTH(DW), .TICKS_PER_UNIT(T), .HDR_MARK_UNITS(HM),
    .HDR_SPACE_UNITS(HS), .ONE_SPACE_UNITS(OS)
  ) dut (
    .In_Clock(clk), .In_Reset(rst), .In_Clock_Pulse(pulse), .In_Valid(valid),
    .In_Data(data), .Out_Ready(ready), .Out_Busy(busy), .Out_Envelope(env),
    .Out_IR(ir), .Out_Done(done)
  );

  initial forever #10 clk = ~clk;

  initial begin
    #1900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Tick generator: random 1-2 cycle high/low levels, or a forced level.
  initial begin
    forever begin
      @(negedge clk);
      if (!pulse_run) begin
        pulse  = pulse_hold;
        g_hold = 0;
      end else if (g_hold > 0) begin
        g_hold--;
      end else begin
        pulse  = ~pulse;
        g_hold = int'($urandom_range(1));
      end
    end
  end

  task automatic check_frame(input int runs[$]);
    logic [DW-1:0] d;
    int er[$];
    int sum;
    int bad;
    int units;
    int got_run;
    chk("done_expected", 64'(exp_q.size() > 0), 1);
    if (exp_q.size() == 0) return;
    d = exp_q.pop_front();
    er.push_back(HM * T);
    er.push_back(HS * T);
    for (int i = DW - 1; i >= 0; i--) begin
      er.push_back(T);
      er.push_back(d[i] ? OS * T : T);
    end
    er.push_back(T);
    chk("run_count", runs.size(), er.size());
    bad = -1;
    foreach (er[i]) if (bad < 0 && (i >= runs.size() || runs[i] != er[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      got_run = (bad < runs.size()) ? runs[bad] : -1;
      $display("FAIL run_len data=%h idx=%0d got=%0d want=%0d", d, bad, got_run, er[bad]);
    end
    sum = 0;
    foreach (runs[i]) sum += runs[i];
    units = HM + HS + (DW - $countones(d)) * 2 + $countones(d) * (1 + OS) + 1;
    chk("frame_ticks", sum, units * T);
    chk("carrier", ir_err, 0);
    ir_err = 0;
    chk("ready_with_done", ready, 1);
    frames_done++;
    $display("frame %0d data=%h units=%0d ticks=%0d", frames_done, d, units, sum);
  endtask

  // Monitor: samples just after each edge; a tick belongs to the run shown before the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_prev = 1'b1; m_cnt = 0; m_env = 1'b0; m_in_frame = 1'b0;
        m_runs.delete(); mark_idx = 0;
        if (ir !== 1'b0 || env !== 1'b0) ir_err++;
      end else begin
        if (pulse && !m_prev) m_cnt++;
        m_prev = pulse;
        if (env !== m_env) begin
          if (env) begin
            if (!m_in_frame) begin
              m_in_frame = 1'b1; m_runs.delete(); mark_idx = 0;
            end else m_runs.push_back(m_cnt);
            mark_idx++;
          end else m_runs.push_back(m_cnt);
          m_cnt = 0;
          m_env = env;
        end
        if (ir !== (env && (m_cnt % 4) < 2)) ir_err++;
        if (busy !== !ready) ir_err++;
        if (done) begin
          check_frame(m_runs);
          m_in_frame = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit expect_done);
    int n;
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    n = 0;
    while (ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 20000), 1);
    if (expect_done) chk("accept_in_done_cycle", done, 1);
    exp_q.push_back(d);
    @(negedge clk);
    valid = 1'b0;
    data  = $urandom;
    chk("env_after_accept", env, 1);
    chk("ir_after_accept", ir, 1);
    chk("ready_after_accept", ready, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 64'(n < 20000), 1);
  endtask

  task automatic wait_mark(input int k);
    int n;
    n = 0;
    while (mark_idx < k && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("mark_timeout", 64'(n < 20000), 1);
  endtask

  initial begin
    int fd;
    repeat (4) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_env", env, 0);
    chk("rst_ir", ir, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    pulse_hold = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_ready", ready, 1);
    chk("idle_ir", ir, 0);
    chk("idle_env", env, 0);
    pulse_run = 1'b1;

    send(32'h0000_0001, 1'b0);
    wait_done();
    send(32'hFFFF_FFFF, 1'b0);
    wait_done();

    send($urandom, 1'b0);
    wait_mark(5);
    @(negedge clk);
    valid = 1'b1;
    data  = $urandom;
    chk("midframe_ready", ready, 0);
    chk("midframe_busy", busy, 1);
    send($urandom, 1'b1);
    wait_done();

    send($urandom, 1'b0);
    wait_mark(11);
    rst = 1'b1;
    exp_q.delete();
    fd = frames_done;
    @(negedge clk);
    chk("abort_ir", ir, 0);
    chk("abort_env", env, 0);
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("no_done_after_abort", frames_done, fd);
    send($urandom, 1'b0);
    wait_done();

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(5)) @(negedge clk);
      send($urandom, 1'b0);
      wait_done();
    end

    repeat (10) @(negedge clk);
    chk("carrier_idle", ir_err, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ir_transmitter.md
# ir_transmitter

Serial infrared frame transmitter that sits directly downstream of the IR tick generator. It edge-detects the ~144 kHz pulse produced by that generator, derives a 36 kHz carrier of 4 ticks per carrier cycle, and drives a pulse-distance–coded frame onto the IR LED output. Each frame has a header, DATA_WIDTH data bits sent MSB first, and a stop mark. Frames are accepted through a valid/ready handshake from the control logic.

## Interface
- DATA_WIDTH, 32: payload bits per frame (1–64).
- TICKS_PER_UNIT, 64: ticks per timing unit (64 ticks = 16 carrier cycles).
- HDR_MARK_UNITS, 16: header mark length in units.
- HDR_SPACE_UNITS, 8: header space length in units.
- ONE_SPACE_UNITS, 3: space length in units for a logic-1 bit. A logic-0 space is 1 unit.
- In_Clock  in  1  system clock (50 MHz). Single clock domain.
- In_Reset  in  1  reset, synchronous and active-high.
- In_Clock_Pulse  in  1  ~144 kHz square pulse from the tick generator. Level signal, same clock domain.
- In_Valid  in  1  a frame is offered on In_Data.
- In_Data  in  DATA_WIDTH  payload to transmit.
- Out_Ready  out  1  block is idle and can accept a frame.
- Out_Busy  out  1  a frame is in progress.
- Out_Envelope  out  1  unmodulated mark envelope (1 = mark).
- Out_IR  out  1  carrier-modulated LED drive.
- Out_Done  out  1  one-cycle strobe at the end of a frame.

## Operation
- Tick: tick = In_Clock_Pulse & ~prev, where prev is In_Clock_Pulse registered. prev resets to 1, so a high pulse at reset release gives no tick.
- States:
  - IDLE: Out_Ready=1, Out_Busy=0, Out_Envelope=0.
  - HDR_MARK: envelope 1, length HDR_MARK_UNITS.
  - HDR_SPACE: envelope 0, length HDR_SPACE_UNITS.
  - BIT_MARK: envelope 1, length 1 unit.
  - BIT_SPACE: envelope 0, length 1 unit, or ONE_SPACE_UNITS if the current bit is 1.
  - STOP_MARK: envelope 1, length 1 unit.
- Accept: In_Valid & Out_Ready. In_Data is latched into a shift register, the bit counter is cleared, and the next state is HDR_MARK. Data changes after acceptance have no effect.
- Segment counter:
  - Width ceil(log2(max segment ticks)).
  - Cleared on every state entry and incremented on each tick.
  - A segment of L units ends on the tick where counter == L*TICKS_PER_UNIT−1. The transition happens on that clock edge.
- Transitions:
  - HDR_MARK→HDR_SPACE→BIT_MARK.
  - BIT_MARK→BIT_SPACE.
  - BIT_SPACE→BIT_MARK while bits remain, otherwise →STOP_MARK. The shift register shifts left at the end of BIT_SPACE.
  - STOP_MARK→IDLE. Out_Done=1 on the cycle the state is IDLE immediately after STOP_MARK.
- Carrier:
  - A 2-bit phase counter is reset to 0 on entry to each mark state and advances on each tick during a mark.
  - Out_IR = Out_Envelope & (phase < 2).
  - Per tick during a mark the LED pattern is 1,1,0,0 repeating. Out_IR is 0 in every space and in IDLE.
- In_Valid while busy is ignored, with Out_Ready=0. There is no queuing.
- Reset mid-frame: all state returns to IDLE on the next edge. Out_IR and Out_Envelope go to 0 and no Out_Done is issued.

## Timing
- Reset values: Out_Ready=1, Out_Busy=0, Out_Envelope=0, Out_IR=0, Out_Done=0.
- Latency: Out_Envelope and Out_IR rise on the clock after acceptance. They do not wait for a tick.
- First-segment rule: the header mark therefore lasts between HDR_MARK_UNITS*TICKS_PER_UNIT−1 and HDR_MARK_UNITS*TICKS_PER_UNIT tick periods. All later segments are exact.
- All outputs are registered, with no combinational path from inputs to outputs.
- Out_Ready rises in the same cycle as Out_Done. A new frame may be accepted that cycle, and the next header starts on the following cycle.
- Frame length in units = HDR_MARK_UNITS + HDR_SPACE_UNITS + zeros*2 + ones*(1+ONE_SPACE_UNITS) + 1.
- A tick coincident with acceptance is not counted.

## Test plan
- Reset, then hold In_Clock_Pulse high, then low. Required: no tick is counted, Out_Ready=1, and Out_IR=0 throughout.
- Send In_Data=0x00000001 with defaults. Required: Out_Envelope shows 16 mark / 8 space units, 31×(1 mark + 1 space), 1 mark + 3 space, then 1 mark. Total 91 units (5824 ticks). Out_Done pulses once.
- Send In_Data=0xFFFFFFFF. Required: 153 units total. Check every BIT_SPACE is 192 ticks.
- Carrier check during any mark: Out_IR per tick is 1,1,0,0. The first two ticks after each mark starts are high. Out_IR is 0 in all spaces.
- Assert In_Valid with new data mid-frame. Required: the data is ignored and Out_Ready=0. Then hold In_Valid through Out_Done. Required: the second frame is accepted in the Out_Done cycle and its header starts on the next clock.
- Assert In_Reset during the 10th BIT_MARK. Required: Out_IR=0, Out_Envelope=0, Out_Ready=1 on the next edge, and no Out_Done. A new frame sent afterwards is bit-exact.
